// File: rtl/data_cache.sv
// Direct-mapped, write-through / write-allocate data cache with a two-state miss FSM.
// Optional hit/miss statistics counters are enabled by defining DATA_CACHE_STATS_EN.
module data_cache #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int SETS          = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
    input  logic                     cpu_re,
    input  logic                     cpu_we,
    input  logic [DATA_WIDTH-1:0]    cpu_wd,
    output logic [DATA_WIDTH-1:0]    cpu_rd,
    output logic                     stall,
    output logic [ADDRESS_WIDTH-1:0] mem_a,
    output logic [DATA_WIDTH-1:0]    mem_wd,
    output logic                     mem_we,
    input  logic [DATA_WIDTH-1:0]    mem_rd,
    output logic [31:0]              hit_count,
    output logic [31:0]              miss_count
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = ADDRESS_WIDTH - 2 - IDX_W;

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] FETCH = 1'b1;

    logic [0:0]            state_q, state_d;
    logic [SETS-1:0]       valid_q;
    logic [TAG_W-1:0]      tag_q  [SETS];
    logic [DATA_WIDTH-1:0] data_q [SETS];

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic                  hit;
    logic                  rd_miss;
    logic                  st_req;
    logic                  line_we;
    logic [DATA_WIDTH-1:0] line_wd;
    logic                  unused_addr_lsb;

    assign idx             = cpu_addr[2 +: IDX_W];
    assign tag             = cpu_addr[ADDRESS_WIDTH-1 -: TAG_W];
    assign unused_addr_lsb = ^cpu_addr[1:0];

    assign hit     = valid_q[idx] && (tag_q[idx] == tag);
    assign st_req  = (state_q == IDLE) && cpu_we;
    assign rd_miss = (state_q == IDLE) && cpu_re && !cpu_we && !hit;

    // A store always allocates; a fill commits the memory word on the edge leaving FETCH.
    assign line_we = st_req || (state_q == FETCH);
    assign line_wd = (state_q == FETCH) ? mem_rd : cpu_wd;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (rd_miss) state_d = FETCH;
            FETCH:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            valid_q <= '0;
        end else begin
            state_q <= state_d;
            if (line_we) valid_q[idx] <= 1'b1;
        end
    end

    // Tag/data arrays carry no reset; valid_q alone decides whether a line is usable.
    always_ff @(posedge clk) begin
        if (line_we) begin
            tag_q[idx]  <= tag;
            data_q[idx] <= line_wd;
        end
    end

    // Outputs are forced quiet while reset is held so the CPU sees no spurious stall.
    assign stall  = rst_n && (rd_miss || (state_q == FETCH));
    assign mem_we = rst_n && st_req;
    assign mem_a  = {cpu_addr[ADDRESS_WIDTH-1:2], 2'b00};
    assign mem_wd = cpu_wd;
    assign cpu_rd = (rst_n && hit) ? data_q[idx] : '0;

`ifdef DATA_CACHE_STATS_EN
    logic        rd_hit;
    logic [31:0] hit_cnt_q, miss_cnt_q;

    assign rd_hit = (state_q == IDLE) && cpu_re && !cpu_we && hit;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit_cnt_q  <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (rd_hit && (hit_cnt_q != 32'hFFFF_FFFF))   hit_cnt_q  <= hit_cnt_q + 32'd1;
            if (rd_miss && (miss_cnt_q != 32'hFFFF_FFFF)) miss_cnt_q <= miss_cnt_q + 32'd1;
        end
    end

    assign hit_count  = hit_cnt_q;
    assign miss_count = miss_cnt_q;
`else
    assign hit_count  = '0;
    assign miss_count = '0;
`endif

endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: a per-cycle vector table plus hand-written
// sequences for reset-during-fill and the statistics counters.
module tb_data_cache;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] cpu_addr;
    logic        cpu_re, cpu_we;
    logic [31:0] cpu_wd, cpu_rd;
    logic        stall;
    logic [31:0] mem_a, mem_wd, mem_rd;
    logic        mem_we;
    logic [31:0] hit_count, miss_count;

    int checks = 0;
    int errors = 0;

    data_cache #(.ADDRESS_WIDTH(32), .DATA_WIDTH(32), .SETS(32)) dut (
        .clk(clk), .rst_n(rst_n), .cpu_addr(cpu_addr), .cpu_re(cpu_re), .cpu_we(cpu_we),
        .cpu_wd(cpu_wd), .cpu_rd(cpu_rd), .stall(stall), .mem_a(mem_a), .mem_wd(mem_wd),
        .mem_we(mem_we), .mem_rd(mem_rd), .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    // Read-only backing store, combinational from mem_a.
    function automatic logic [31:0] memf(input logic [31:0] a);
        case (a)
            32'h0000_0100: memf = 32'hDEAD_BEEF;
            32'h0000_0004: memf = 32'h1111_0004;
            32'h0000_0084: memf = 32'h2222_0084;
            32'h0000_0040: memf = 32'h3333_0040;
            default:       memf = 32'hBAD0_0000 | a;
        endcase
    endfunction
    assign mem_rd = memf(mem_a);

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    typedef struct {
        logic        re, we;
        logic [31:0] addr, wd;
        logic        e_stall, e_mwe;
        logic        c_rd;  logic [31:0] e_rd;
        logic        c_ma;  logic [31:0] e_ma;
        logic        c_wd;  logic [31:0] e_wd;
    } vec_t;

    function automatic vec_t mk(input logic re, input logic we, input logic [31:0] addr,
                                input logic [31:0] wd, input logic e_stall, input logic e_mwe,
                                input logic c_rd, input logic [31:0] e_rd,
                                input logic c_ma, input logic [31:0] e_ma,
                                input logic c_wd, input logic [31:0] e_wd);
        vec_t v;
        v.re = re; v.we = we; v.addr = addr; v.wd = wd;
        v.e_stall = e_stall; v.e_mwe = e_mwe;
        v.c_rd = c_rd; v.e_rd = e_rd; v.c_ma = c_ma; v.e_ma = e_ma;
        v.c_wd = c_wd; v.e_wd = e_wd;
        return v;
    endfunction

    vec_t vt[18];

    task automatic drive(input logic re, input logic we, input logic [31:0] addr,
                         input logic [31:0] wd);
        cpu_re = re; cpu_we = we; cpu_addr = addr; cpu_wd = wd;
    endtask

    initial begin
        // miss 0x100 (2 stall cycles), then hits
        vt[0]  = mk(1,0,32'h100,0,          1,0, 0,0,            0,0,      0,0);
        vt[1]  = mk(1,0,32'h100,0,          1,0, 0,0,            1,32'h100,0,0);
        vt[2]  = mk(1,0,32'h100,0,          0,0, 1,32'hDEADBEEF, 0,0,      0,0);
        vt[3]  = mk(1,0,32'h100,0,          0,0, 1,32'hDEADBEEF, 0,0,      0,0);
        // store 0x200 write-through, then read hit
        vt[4]  = mk(0,1,32'h200,32'h12345678,0,1, 0,0,           1,32'h200,1,32'h12345678);
        vt[5]  = mk(1,0,32'h200,0,          0,0, 1,32'h12345678, 0,0,      0,0);
        // 0x4 and 0x84 share index 1 and evict each other
        vt[6]  = mk(1,0,32'h004,0,          1,0, 0,0,            0,0,      0,0);
        vt[7]  = mk(1,0,32'h004,0,          1,0, 0,0,            1,32'h004,0,0);
        vt[8]  = mk(1,0,32'h004,0,          0,0, 1,32'h11110004, 0,0,      0,0);
        vt[9]  = mk(1,0,32'h084,0,          1,0, 0,0,            0,0,      0,0);
        vt[10] = mk(1,0,32'h084,0,          1,0, 0,0,            1,32'h084,0,0);
        vt[11] = mk(1,0,32'h084,0,          0,0, 1,32'h22220084, 0,0,      0,0);
        vt[12] = mk(1,0,32'h004,0,          1,0, 0,0,            0,0,      0,0);
        vt[13] = mk(1,0,32'h004,0,          1,0, 0,0,            1,32'h004,0,0);
        vt[14] = mk(1,0,32'h004,0,          0,0, 1,32'h11110004, 0,0,      0,0);
        // re and we together: store only, no stall
        vt[15] = mk(1,1,32'h010,32'hA5A5A5A5,0,1, 0,0,           1,32'h010,1,32'hA5A5A5A5);
        vt[16] = mk(1,0,32'h010,0,          0,0, 1,32'hA5A5A5A5, 0,0,      0,0);
        vt[17] = mk(0,0,32'h010,0,          0,0, 0,0,            0,0,      0,0);

        // reset with a read pending: outputs must stay quiet
        rst_n = 1'b0;
        drive(1, 0, 32'h100, 0);
        #1;
        chk("rst stall",  {31'b0, stall},  0);
        chk("rst mem_we", {31'b0, mem_we}, 0);
        chk("rst cpu_rd", cpu_rd, 0);
        chk("rst hit_count", hit_count, 0);
        chk("rst miss_count", miss_count, 0);
        repeat (2) @(posedge clk);

        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            rst_n = 1'b1;
            drive(vt[i].re, vt[i].we, vt[i].addr, vt[i].wd);
            #1;
            chk($sformatf("v%0d stall", i),  {31'b0, stall},  {31'b0, vt[i].e_stall});
            chk($sformatf("v%0d mem_we", i), {31'b0, mem_we}, {31'b0, vt[i].e_mwe});
            if (vt[i].c_rd) chk($sformatf("v%0d cpu_rd", i), cpu_rd, vt[i].e_rd);
            if (vt[i].c_ma) chk($sformatf("v%0d mem_a", i),  mem_a,  vt[i].e_ma);
            if (vt[i].c_wd) chk($sformatf("v%0d mem_wd", i), mem_wd, vt[i].e_wd);
        end
        @(negedge clk); #1;
`ifdef DATA_CACHE_STATS_EN
        chk("tbl hit_count", hit_count, 7);
        chk("tbl miss_count", miss_count, 4);
`else
        chk("tbl hit_count", hit_count, 0);
        chk("tbl miss_count", miss_count, 0);
`endif

        // reset pulsed during the FETCH cycle of a miss to 0x40
        @(negedge clk);
        drive(1, 0, 32'h40, 0);
        #1 chk("rf miss stall", {31'b0, stall}, 1);
        @(negedge clk);
        #1 chk("rf fetch stall", {31'b0, stall}, 1);
        rst_n = 1'b0;
        #1;
        chk("rf rst stall",  {31'b0, stall},  0);
        chk("rf rst mem_we", {31'b0, mem_we}, 0);
        chk("rf rst cpu_rd", cpu_rd, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1 chk("rf re-miss stall", {31'b0, stall}, 1);
        @(negedge clk);
        #1 chk("rf fetch2 stall", {31'b0, stall}, 1);
        @(negedge clk);
        #1;
        chk("rf hit1 stall", {31'b0, stall}, 0);
        chk("rf hit1 cpu_rd", cpu_rd, 32'h3333_0040);
        @(negedge clk);
        #1 chk("rf hit2 stall", {31'b0, stall}, 0);
        @(negedge clk);
        drive(0, 1, 32'h60, 32'h0BAD_F00D);
        #1;
        chk("st60 stall", {31'b0, stall}, 0);
        chk("st60 mem_we", {31'b0, mem_we}, 1);
        @(negedge clk);
        drive(1, 0, 32'h100, 0);
        #1 chk("m100 stall", {31'b0, stall}, 1);
        @(negedge clk);
        #1;
`ifdef DATA_CACHE_STATS_EN
        chk("seq hit_count", hit_count, 2);
        chk("seq miss_count", miss_count, 2);
`else
        chk("seq hit_count", hit_count, 0);
        chk("seq miss_count", miss_count, 0);
`endif
        @(negedge clk);
        #1;
        chk("m100 cpu_rd", cpu_rd, 32'hDEAD_BEEF);
        chk("m100 stall after", {31'b0, stall}, 0);
        drive(0, 0, 32'h0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
